hemaia_mem_to_axi: RTL and testbench
====================================

# hemaia_mem_to_axi

Bridge from a single-port memory-style request interface (req/gnt, in-order rvalid) to a wide AXI4 master port: the initiator counterpart of the memory system's AXI-to-memory path. Sits in front of the wide AXI crossbar so that accelerators and test loaders with a plain memory interface can read and write HeMAiA main memory and XDMA regions. Each memory request becomes one single-beat AXI transaction; responses return to the memory side strictly in issue order, independent of AXI R/B channel interleaving.

## Interface
- `axi_req_t`, logic: AXI request struct (AW/W/AR/B-ready/R-ready), same shape as the wide master types.
- `axi_rsp_t`, logic: matching AXI response struct.
- `AddrWidth`, 48: AXI and memory address width.
- `DataWidth`, 512: data width; power of two, ≥ 64.
- `IdWidth`, 2: AXI ID width.
- `AxiId`, 0: constant ID driven on AW and AR.
- `MaxOutstanding`, 8: maximum granted-but-unanswered requests; ≥ 1.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `mem_req_i` in 1: request valid; held with stable payload until `mem_gnt_o`.
- `mem_gnt_o` out 1: request accepted this cycle.
- `mem_addr_i` in AddrWidth: byte address, DataWidth/8-aligned.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_wdata_i` in DataWidth: write data.
- `mem_strb_i` in DataWidth/8: byte enables.
- `mem_rvalid_o` out 1: response pulse, one per granted request (reads and writes), in grant order.
- `mem_rdata_o` out DataWidth: read data, valid with `mem_rvalid_o` for reads.
- `mem_err_o` out 1: response was SLVERR/DECERR (`resp[1]`).
- `axi_req_o` out axi_req_t: AXI master request.
- `axi_rsp_i` in axi_rsp_t: AXI master response.

## Operation
- AW/AR fields: addr = `mem_addr_i`, id = `AxiId`, len = 0, size = log2(DataWidth/8), burst = INCR, cache/prot/qos/region/atop/user = 0, lock = 0. W: data, strb, last = 1, user = 0.
- Issue allowed only when outstanding counter `cnt` < MaxOutstanding (pop in same cycle does not free a slot).
- Read: `ar_valid` = `mem_req_i` & !`mem_we_i` & slot free; `mem_gnt_o` = AR handshake.
- Write: `aw_valid` = `mem_req_i` & `mem_we_i` & slot free & !`aw_sent`; `w_valid` likewise with !`w_sent`. `aw_sent`/`w_sent` flags set on their handshake if the other has not yet completed; `mem_gnt_o` in the cycle the second of AW/W handshakes completes (or both same cycle); flags cleared on grant. Once either flag is set, issue proceeds regardless of slot check (slot reserved by first handshake).
- Order FIFO (depth MaxOutstanding, 1 bit: is_write) pushed on grant; `cnt` increments on push, decrements on pop, both same cycle = unchanged.
- `r_ready` = FIFO non-empty & head is read; `b_ready` = non-empty & head is write. Pop on R or B handshake. R/B arriving for non-head type stall (never dropped).
- Response register: on pop, `mem_rvalid_o` = 1 next cycle, `mem_rdata_o` = R data (reads) else unchanged, `mem_err_o` = resp[1]. No back-pressure on memory response side.

## Timing
- Reset values: all AXI valids/readies 0, `mem_gnt_o` 0, `mem_rvalid_o` 0, `mem_rdata_o` 0, `mem_err_o` 0, flags 0, FIFO empty, `cnt` 0.
- Request path combinational: `mem_req_i` → AXI valid same cycle; `mem_gnt_o` same cycle as final handshake.
- Response latency: exactly 1 cycle from R/B handshake to `mem_rvalid_o`. Max throughput 1 request and 1 response per cycle.
- Reset mid-operation: all in-flight state discarded immediately; no responses for pre-reset requests.
- `cnt` width `$clog2(MaxOutstanding+1)`; never exceeds MaxOutstanding nor underflows.

## Test plan
- Single read addr 0x80000040, R data 0xA5.. after 3 cycles → gnt in AR cycle, `mem_rvalid_o` 1 cycle after R handshake, rdata 0xA5.., err 0.
- Write with AW ready at cycle 0, W ready at cycle 4 → `aw_valid` drops after cycle 0, gnt at cycle 4, one `mem_rvalid_o` after B.
- Read, write, read issued; slave returns B before R → B stalled (`b_ready` 0) until first R; rvalid order R, W, R.
- MaxOutstanding=8, slave withholds responses → 8 grants, 9th `mem_req_i` sees no AXI valid and no gnt until one response pops.
- R with resp=DECERR → `mem_err_o` 1 with `mem_rvalid_o`; subsequent OKAY response → err 0.
- Assert `rst_ni` low with 3 outstanding → all outputs reset next edge, later stray R/B not accepted (`r_ready`/`b_ready` 0).

Source files
------------

// File: rtl/hemaia_mem_to_axi_if.sv
// rtl/hemaia_mem_to_axi_if.sv - memory-request and AXI4 bus interfaces of the mem-to-AXI bridge
interface hemaia_mem_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 512
) ();
    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] strb;
    logic                   rvalid;
    logic [DataWidth-1:0]   rdata;
    logic                   err;

    modport master (output req, addr, we, wdata, strb, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, wdata, strb, output gnt, rvalid, rdata, err);
endinterface

interface hemaia_axi_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned IdWidth   = 2
) ();
    logic [IdWidth-1:0]     aw_id;
    logic [AddrWidth-1:0]   aw_addr;
    logic [7:0]             aw_len;
    logic [2:0]             aw_size;
    logic [1:0]             aw_burst;
    logic                   aw_lock;
    logic [3:0]             aw_cache;
    logic [2:0]             aw_prot;
    logic [3:0]             aw_qos;
    logic [3:0]             aw_region;
    logic [5:0]             aw_atop;
    logic                   aw_user;
    logic                   aw_valid;
    logic                   aw_ready;

    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   w_last;
    logic                   w_user;
    logic                   w_valid;
    logic                   w_ready;

    logic [IdWidth-1:0]     b_id;
    logic [1:0]             b_resp;
    logic                   b_user;
    logic                   b_valid;
    logic                   b_ready;

    logic [IdWidth-1:0]     ar_id;
    logic [AddrWidth-1:0]   ar_addr;
    logic [7:0]             ar_len;
    logic [2:0]             ar_size;
    logic [1:0]             ar_burst;
    logic                   ar_lock;
    logic [3:0]             ar_cache;
    logic [2:0]             ar_prot;
    logic [3:0]             ar_qos;
    logic [3:0]             ar_region;
    logic                   ar_user;
    logic                   ar_valid;
    logic                   ar_ready;

    logic [IdWidth-1:0]     r_id;
    logic [DataWidth-1:0]   r_data;
    logic [1:0]             r_resp;
    logic                   r_last;
    logic                   r_user;
    logic                   r_valid;
    logic                   r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/hemaia_mem_to_axi.sv
// rtl/hemaia_mem_to_axi.sv - memory req/gnt to single-beat AXI4 master bridge with in-order responses
module hemaia_mem_to_axi #(
    parameter int unsigned        AddrWidth      = 48,
    parameter int unsigned        DataWidth      = 512,
    parameter int unsigned        IdWidth        = 2,
    parameter logic [IdWidth-1:0] AxiId          = '0,
    parameter int unsigned        MaxOutstanding = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    hemaia_mem_if.slave  mem,
    hemaia_axi_if.master axi
);
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [2:0]  AxiSize   = 3'($clog2(DataWidth / 8));
    localparam logic [1:0]  BurstIncr = 2'b01;

    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic                      aw_sent_q, aw_sent_d;
    logic                      w_sent_q, w_sent_d;
    logic [MaxOutstanding-1:0] order_q, order_d;
    logic [PtrWidth-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]       rd_ptr_q, rd_ptr_d;
    logic                      rvalid_q;
    logic [DataWidth-1:0]      rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic slot_free, issue_ok;
    logic ar_hs, aw_hs, w_hs, wr_gnt, gnt;
    logic fifo_empty, head_is_write;
    logic r_hs, b_hs, push, pop;
    logic unused_rsp;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(MaxOutstanding - 1)) begin
            return '0;
        end
        return ptr + PtrWidth'(1);
    endfunction

    assign slot_free = cnt_q < CntWidth'(MaxOutstanding);
    // A write with one half already on the bus owns the slot it reserved then.
    assign issue_ok  = slot_free | aw_sent_q | w_sent_q;

    assign axi.ar_valid = mem.req & ~mem.we & slot_free;
    assign axi.aw_valid = mem.req & mem.we & issue_ok & ~aw_sent_q;
    assign axi.w_valid  = mem.req & mem.we & issue_ok & ~w_sent_q;

    assign ar_hs  = axi.ar_valid & axi.ar_ready;
    assign aw_hs  = axi.aw_valid & axi.aw_ready;
    assign w_hs   = axi.w_valid & axi.w_ready;
    assign wr_gnt = mem.req & mem.we & (aw_sent_q | aw_hs) & (w_sent_q | w_hs);
    assign gnt    = ar_hs | wr_gnt;
    assign push   = gnt;

    assign axi.ar_id     = AxiId;
    assign axi.ar_addr   = mem.addr;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = AxiSize;
    assign axi.ar_burst  = BurstIncr;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = 1'b0;

    assign axi.aw_id     = AxiId;
    assign axi.aw_addr   = mem.addr;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = AxiSize;
    assign axi.aw_burst  = BurstIncr;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_atop   = 6'd0;
    assign axi.aw_user   = 1'b0;

    assign axi.w_data = mem.wdata;
    assign axi.w_strb = mem.strb;
    assign axi.w_last = 1'b1;
    assign axi.w_user = 1'b0;

    // Only the response type at the head of the order FIFO is accepted; the other channel stalls.
    assign fifo_empty    = (cnt_q == '0);
    assign head_is_write = order_q[rd_ptr_q];
    assign axi.r_ready   = ~fifo_empty & ~head_is_write;
    assign axi.b_ready   = ~fifo_empty & head_is_write;
    assign r_hs          = axi.r_valid & axi.r_ready;
    assign b_hs          = axi.b_valid & axi.b_ready;
    assign pop           = r_hs | b_hs;

    assign mem.gnt    = gnt;
    assign mem.rvalid = rvalid_q;
    assign mem.rdata  = rdata_q;
    assign mem.err    = err_q;

    assign unused_rsp = ^{axi.b_id, axi.b_resp[0], axi.b_user,
                          axi.r_id, axi.r_resp[0], axi.r_last, axi.r_user};

    always_comb begin
        aw_sent_d = aw_sent_q;
        w_sent_d  = w_sent_q;
        if (gnt) begin
            aw_sent_d = 1'b0;
            w_sent_d  = 1'b0;
        end else begin
            if (aw_hs) aw_sent_d = 1'b1;
            if (w_hs)  w_sent_d  = 1'b1;
        end
    end

    always_comb begin
        order_d  = order_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            order_d[wr_ptr_q] = mem.we;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (r_hs) begin
            rdata_d = axi.r_data;
            err_d   = axi.r_resp[1];
        end else if (b_hs) begin
            err_d   = axi.b_resp[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
            order_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            aw_sent_q <= aw_sent_d;
            w_sent_q  <= w_sent_d;
            order_q   <= order_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rvalid_q  <= pop;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_hemaia_mem_to_axi.sv
// tb/tb_hemaia_mem_to_axi.sv - randomized self-checking bench for hemaia_mem_to_axi
module tb_hemaia_mem_to_axi;
    localparam int AW   = 48;
    localparam int DW   = 512;
    localparam int SW   = DW / 8;
    localparam int OFF  = $clog2(SW);
    localparam int IW   = 2;
    localparam int MAXO = 8;
    localparam logic [IW-1:0] AXI_ID = 2'd2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hemaia_mem_if #(.AddrWidth(AW), .DataWidth(DW)) mem ();
    hemaia_axi_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) axi ();

    hemaia_mem_to_axi #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .AxiId(AXI_ID), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem(mem), .axi(axi)
    );

    typedef struct packed {
        logic          is_write;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          axi_q[$];   // granted, waiting for AXI response, in grant order
    rsp_t          rd_q[$];    // slave view of accepted reads
    rsp_t          wr_q[$];    // slave view of accepted writes
    rsp_t          exp_rsp;
    logic          exp_rv;
    logic [DW-1:0] last_rdata;
    logic          req_act, aw_done, w_done, r_hold, b_hold;
    int            p_req, p_ready, p_rsp;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [1:0] pick_resp(input logic err);
        if (!err) return 2'b00;
        return ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    endfunction

    function automatic logic chance(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic clear_model();
        axi_q.delete();
        rd_q.delete();
        wr_q.delete();
        exp_rv     = 1'b0;
        last_rdata = '0;
        req_act    = 1'b0;
        aw_done    = 1'b0;
        w_done     = 1'b0;
        r_hold     = 1'b0;
        b_hold     = 1'b0;
    endtask

    task automatic drive();
        logic [63:0]   a;
        logic [DW-1:0] s;
        if (!req_act && chance(p_req)) begin
            a         = {$urandom(), $urandom()};
            s         = rand_wide();
            req_act   = 1'b1;
            mem.we    = chance(50);
            mem.addr  = {a[AW-1:OFF], {OFF{1'b0}}};
            mem.wdata = rand_wide();
            mem.strb  = s[SW-1:0];
        end
        mem.req      = req_act;
        axi.ar_ready = chance(p_ready);
        axi.aw_ready = chance(p_ready);
        axi.w_ready  = chance(p_ready);
        if (!r_hold && rd_q.size() > 0 && chance(p_rsp)) begin
            r_hold      = 1'b1;
            axi.r_data  = rd_q[0].data;
            axi.r_resp  = pick_resp(rd_q[0].err);
        end
        if (!b_hold && wr_q.size() > 0 && chance(p_rsp)) begin
            b_hold      = 1'b1;
            axi.b_resp  = pick_resp(wr_q[0].err);
        end
        axi.r_valid = r_hold;
        axi.b_valid = b_hold;
    endtask

    task automatic sample();
        logic slot, ar_hs, aw_hs, w_hs, exp_gnt, head_wr, have;
        rsp_t ent;
        check_eq("rvalid", mem.rvalid, exp_rv);
        if (exp_rv) begin
            check_eq("err", mem.err, exp_rsp.err);
            check_eq("rdata", mem.rdata, exp_rsp.is_write ? last_rdata : exp_rsp.data);
            if (!exp_rsp.is_write) last_rdata = exp_rsp.data;
        end

        slot = axi_q.size() < MAXO;
        check_eq("ar_valid", axi.ar_valid, mem.req & ~mem.we & slot);
        check_eq("aw_valid", axi.aw_valid, mem.req & mem.we & ~aw_done & (slot | w_done));
        check_eq("w_valid", axi.w_valid, mem.req & mem.we & ~w_done & (slot | aw_done));
        if (axi.ar_valid)
            check_eq("ar_fields",
                {axi.ar_addr, axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock,
                 axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_user},
                {mem.addr, AXI_ID, 8'd0, 3'd6, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
        if (axi.aw_valid)
            check_eq("aw_fields",
                {axi.aw_addr, axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock,
                 axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_atop, axi.aw_user},
                {mem.addr, AXI_ID, 8'd0, 3'd6, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0});
        if (axi.w_valid) begin
            check_eq("w_data", axi.w_data, mem.wdata);
            check_eq("w_ctl", {axi.w_strb, axi.w_last, axi.w_user}, {mem.strb, 1'b1, 1'b0});
        end

        ar_hs   = axi.ar_valid & axi.ar_ready;
        aw_hs   = axi.aw_valid & axi.aw_ready;
        w_hs    = axi.w_valid & axi.w_ready;
        exp_gnt = ar_hs | (mem.req & mem.we & (aw_done | aw_hs) & (w_done | w_hs));
        check_eq("gnt", mem.gnt, exp_gnt);

        have    = axi_q.size() > 0;
        head_wr = have ? axi_q[0].is_write : 1'b0;
        check_eq("r_ready", axi.r_ready, have & ~head_wr);
        check_eq("b_ready", axi.b_ready, have & head_wr);

        exp_rv = 1'b0;
        if (axi.r_valid && axi.r_ready && rd_q.size() > 0) begin
            exp_rsp = rd_q.pop_front();
            exp_rv  = 1'b1;
            r_hold  = 1'b0;
            if (have) ent = axi_q.pop_front();
        end else if (axi.b_valid && axi.b_ready && wr_q.size() > 0) begin
            exp_rsp = wr_q.pop_front();
            exp_rv  = 1'b1;
            b_hold  = 1'b0;
            if (have) ent = axi_q.pop_front();
        end

        if (exp_gnt) begin
            ent.is_write = mem.we;
            ent.err      = ($urandom_range(0, 4) == 0);
            ent.data     = mem.we ? '0 : rand_wide();
            axi_q.push_back(ent);
            if (mem.we) wr_q.push_back(ent);
            else        rd_q.push_back(ent);
            req_act = 1'b0;
            aw_done = 1'b0;
            w_done  = 1'b0;
        end else begin
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run(input int n, input int rq, input int rd, input int rs);
        p_req   = rq;
        p_ready = rd;
        p_rsp   = rs;
        repeat (n) step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rvalid"}, mem.rvalid, 1'b0);
        check_eq({tag, "_rdata"}, mem.rdata, '0);
        check_eq({tag, "_err"}, mem.err, 1'b0);
        check_eq({tag, "_gnt"}, mem.gnt, 1'b0);
        check_eq({tag, "_valids"}, {axi.ar_valid, axi.aw_valid, axi.w_valid}, 3'b000);
        check_eq({tag, "_readies"}, {axi.r_ready, axi.b_ready}, 2'b00);
    endtask

    initial begin
        mem.req = 1'b0; mem.we = 1'b0; mem.addr = '0; mem.wdata = '0; mem.strb = '0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_id = AXI_ID; axi.b_resp = 2'b00; axi.b_user = 1'b0; axi.b_valid = 1'b0;
        axi.r_id = AXI_ID; axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b1;
        axi.r_user = 1'b0; axi.r_valid = 1'b0;
        clear_model();

        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(300, 70, 50, 50);
        run(30, 100, 100, 0);
        check_eq("saturated_outstanding", axi_q.size(), MAXO);
        run(200, 100, 100, 100);
        run(300, 60, 20, 30);

        run(6, 100, 100, 0);
        check_eq("pre_reset_outstanding_ge3", axi_q.size() >= 3, 1'b1);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        mem.req     = 1'b0;
        axi.r_valid = 1'b1;
        axi.r_resp  = 2'b10;
        axi.b_valid = 1'b1;
        axi.b_resp  = 2'b10;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("stray_r_ready", axi.r_ready, 1'b0);
            check_eq("stray_b_ready", axi.b_ready, 1'b0);
            check_eq("stray_rvalid", mem.rvalid, 1'b0);
            @(posedge clk);
            #1;
        end
        axi.r_valid = 1'b0;
        axi.b_valid = 1'b0;
        clear_model();

        run(300, 70, 60, 60);
        p_req   = 0;
        p_ready = 100;
        p_rsp   = 100;
        for (int i = 0; i < 300 && (axi_q.size() > 0 || req_act || exp_rv); i++) step();
        check_eq("drained", (axi_q.size() == 0) && !req_act && !exp_rv, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
